// File: rtl/fsm_convert_float_to_fixed.sv
// Sequencer for the float-to-fixed converter: capture, compare, shift, capture, handshake.
// Optional early-exit overflow detection is enabled by defining CFF_OVERFLOW_DET_EN.
module fsm_convert_float_to_fixed #(
  parameter int unsigned LAT_SHIFT = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BEG_FSM_CFF,
  input  logic       Exp_out,
  input  logic [7:0] Exp,
  output logic       EN_REG1,
  output logic       LOAD,
  output logic       MS_1,
  output logic       EN_REG_RESULT,
  output logic       OVF,
  output logic       ACK_FSM_CFF
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD_FLOAT = 3'd1,
    S_COMPARE    = 3'd2,
    S_SHIFT_LOAD = 3'd3,
    S_SHIFT_WAIT = 3'd4,
    S_CAPTURE    = 3'd5,
    S_DONE       = 3'd6
  } state_t;

  // The wait counter runs LAT_SHIFT-1 down to 0, giving LAT_SHIFT cycles in SHIFT_WAIT.
  localparam logic [3:0] WAIT_LOAD = 4'(LAT_SHIFT - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       en_reg1_q, en_reg1_d;
  logic       load_q, load_d;
  logic       ms_1_q, ms_1_d;
  logic       en_res_q, en_res_d;
  logic       ovf_q, ovf_d;
  logic       ack_q, ack_d;
  logic       ovf_hit_s;
  logic       unused_exp_out_s;

  // Exp_out is consumed by the datapath; the sequencer itself does not need it.
  assign unused_exp_out_s = Exp_out;

`ifdef CFF_OVERFLOW_DET_EN
  assign ovf_hit_s = (Exp > 8'd153);
`else
  assign ovf_hit_s = 1'b0;
`endif

  // State and registered Moore outputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      en_reg1_q <= 1'b0;
      load_q    <= 1'b0;
      ms_1_q    <= 1'b0;
      en_res_q  <= 1'b0;
      ovf_q     <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      en_reg1_q <= en_reg1_d;
      load_q    <= load_d;
      ms_1_q    <= ms_1_d;
      en_res_q  <= en_res_d;
      ovf_q     <= ovf_d;
      ack_q     <= ack_d;
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = 4'd0;
        if (BEG_FSM_CFF) begin
          state_d = S_LOAD_FLOAT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD_FLOAT: state_d = S_COMPARE;
      S_COMPARE: begin
        if (ovf_hit_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SHIFT_LOAD;
        end
      end
      S_SHIFT_LOAD: begin
        state_d = S_SHIFT_WAIT;
        cnt_d   = WAIT_LOAD;
      end
      S_SHIFT_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_CAPTURE: state_d = S_DONE;
      S_DONE: begin
        if (BEG_FSM_CFF) begin
          state_d = S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Output decode from the next state so every output is a flop.
  always_comb begin
    en_reg1_d = (state_d == S_LOAD_FLOAT);
    load_d    = (state_d == S_SHIFT_LOAD);
    en_res_d  = (state_d == S_CAPTURE);
    ack_d     = (state_d == S_DONE);
    if (state_d == S_IDLE) begin
      ms_1_d = 1'b0;
    end else if (state_q == S_COMPARE) begin
      ms_1_d = (Exp != 8'd127);
    end else begin
      ms_1_d = ms_1_q;
    end
    if (state_d == S_DONE) begin
      ovf_d = ovf_q | ((state_q == S_COMPARE) & ovf_hit_s);
    end else begin
      ovf_d = 1'b0;
    end
  end

  assign EN_REG1       = en_reg1_q;
  assign LOAD          = load_q;
  assign MS_1          = ms_1_q;
  assign EN_REG_RESULT = en_res_q;
  assign OVF           = ovf_q;
  assign ACK_FSM_CFF   = ack_q;

endmodule

// File: tb/tb_fsm_convert_float_to_fixed.sv
// Directed bench for fsm_convert_float_to_fixed: default instance plus a LAT_SHIFT=4 instance.
module tb_fsm_convert_float_to_fixed;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       beg = 1'b0;
  logic       beg4 = 1'b0;
  logic       exp_out = 1'b0;
  logic [7:0] expv = 8'd0;
  logic [7:0] expv4 = 8'd0;

  logic en_reg1, load, ms_1, en_res, ovf, ack;
  logic en_reg1_4, load_4, ms_1_4, en_res_4, ovf_4, ack_4;

  int n_checks = 0;
  int n_fail = 0;

  // Observation order: EN_REG1, LOAD, EN_REG_RESULT, ACK, MS_1, OVF
  wire [5:0] obs  = {en_reg1, load, en_res, ack, ms_1, ovf};
  wire [5:0] obs4 = {en_reg1_4, load_4, en_res_4, ack_4, ms_1_4, ovf_4};

  always #5 clk = ~clk;

  fsm_convert_float_to_fixed u_dut (
    .CLK(clk), .RST(rst), .BEG_FSM_CFF(beg), .Exp_out(exp_out), .Exp(expv),
    .EN_REG1(en_reg1), .LOAD(load), .MS_1(ms_1), .EN_REG_RESULT(en_res),
    .OVF(ovf), .ACK_FSM_CFF(ack)
  );

  fsm_convert_float_to_fixed #(.LAT_SHIFT(4)) u_dut4 (
    .CLK(clk), .RST(rst), .BEG_FSM_CFF(beg4), .Exp_out(exp_out), .Exp(expv4),
    .EN_REG1(en_reg1_4), .LOAD(load_4), .MS_1(ms_1_4), .EN_REG_RESULT(en_res_4),
    .OVF(ovf_4), .ACK_FSM_CFF(ack_4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] e;
    rst = 1'b0; beg = 1'b0; beg4 = 1'b0;
    step(); step();
    e = 6'b000000;
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_held: got %b expected %b", obs, e); end
    n_checks++;
    if (obs4 !== e) begin n_fail++; $display("FAIL reset_held_lat4: got %b expected %b", obs4, e); end
    rst = 1'b1;
    step();
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_idle: got %b expected %b", obs, e); end
  endtask

  task automatic test_convert_130();
    logic [5:0] e;
    expv = 8'd130; beg = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step();
      e = {c == 1, c == 3, c == 6, c == 7, c >= 3, 1'b0};
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL conv130 cycle %0d: got %b expected %b", c, obs, e); end
      n_checks++;
      if ($countones({en_reg1, load, en_res}) > 1) begin
        n_fail++; $display("FAIL pulse_exclusive cycle %0d: got %b expected at most one", c, {en_reg1, load, en_res});
      end
    end
    beg = 1'b0;
    step();
    e = 6'b000000;
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL conv130_release: got %b expected %b", obs, e); end
  endtask

  task automatic test_ms1_zero();
    logic [5:0] e;
    expv = 8'd127; beg = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step();
      e = {c == 1, c == 3, c == 6, c == 7, 1'b0, 1'b0};
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL exp127 cycle %0d: got %b expected %b", c, obs, e); end
    end
    beg = 1'b0;
    step();
  endtask

  task automatic test_hold();
    logic [5:0] e;
    expv = 8'd130; beg = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      e = {c == 1, c == 3, c == 6, c >= 7, c >= 3, 1'b0};
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL hold cycle %0d: got %b expected %b", c, obs, e); end
    end
    beg = 1'b0;
    e = 6'b000000;
    for (int c = 21; c <= 24; c++) begin
      step();
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL hold_release cycle %0d: got %b expected %b", c, obs, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] e;
    expv = 8'd140; beg = 1'b1;
    for (int c = 1; c <= 7; c++) step();
    beg = 1'b0;
    step();
    e = 6'b000000;
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL b2b_idle_gap: got %b expected %b", obs, e); end
    beg = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step();
      e = {c == 1, c == 3, c == 6, c == 7, c >= 3, 1'b0};
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL b2b_second cycle %0d: got %b expected %b", c, obs, e); end
    end
    beg = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    logic [5:0] e;
    expv = 8'd130; beg = 1'b1;
    for (int c = 1; c <= 4; c++) step();
    e = 6'b000010;
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL midreset_pre: got %b expected %b", obs, e); end
    rst = 1'b0;
    step();
    e = 6'b000000;
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL midreset_clear: got %b expected %b", obs, e); end
    rst = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step();
      e = {c == 1, c == 3, c == 6, c == 7, c >= 3, 1'b0};
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL midreset_restart cycle %0d: got %b expected %b", c, obs, e); end
    end
    beg = 1'b0;
    step();
  endtask

  task automatic test_overflow();
    logic [5:0] e;
    expv = 8'd200; beg = 1'b1;
`ifdef CFF_OVERFLOW_DET_EN
    for (int c = 1; c <= 6; c++) begin
      step();
      e = {c == 1, 1'b0, 1'b0, c >= 3, c >= 3, c >= 3};
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL overflow cycle %0d: got %b expected %b", c, obs, e); end
    end
`else
    for (int c = 1; c <= 7; c++) begin
      step();
      e = {c == 1, c == 3, c == 6, c == 7, c >= 3, 1'b0};
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL exp200_noovf cycle %0d: got %b expected %b", c, obs, e); end
    end
`endif
    beg = 1'b0;
    step();
    e = 6'b000000;
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL exp200_release: got %b expected %b", obs, e); end
  endtask

  task automatic test_lat4();
    logic [5:0] e;
    expv4 = 8'd120; beg4 = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      e = {c == 1, c == 3, c == 8, c == 9, c >= 3, 1'b0};
      n_checks++;
      if (obs4 !== e) begin n_fail++; $display("FAIL lat4 cycle %0d: got %b expected %b", c, obs4, e); end
    end
    beg4 = 1'b0;
    step();
    e = 6'b000000;
    n_checks++;
    if (obs4 !== e) begin n_fail++; $display("FAIL lat4_release: got %b expected %b", obs4, e); end
  endtask

  initial begin
    test_reset();
    test_convert_130();
    test_ms1_zero();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_overflow();
    test_lat4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm_convert_float_to_fixed.md
FSM_CONVERT_FLOAT_TO_FIXED -- requirements
Module: fsm_convert_float_to_fixed

Interface
REQ-001 The block SHALL have parameter LAT_SHIFT, default 2: barrel-shifter cycles waited after LOAD, legal range 1..15.
REQ-002 The block SHALL have port CLK  input  1  the single clock; all state changes on rising edge.
REQ-003 The block SHALL have port RST  input  1  synchronous, active-low reset.
REQ-004 The block SHALL have port BEG_FSM_CFF  input  1  conversion request, level, four-phase handshake.
REQ-005 The block SHALL have port Exp_out  input  1  registered "exponent > 127" flag from the converter.
REQ-006 The block SHALL have port Exp  input  8  biased exponent of the captured float.
REQ-007 The block SHALL have port EN_REG1  output  1  one-cycle capture pulse for the float register.
REQ-008 The block SHALL have port LOAD  output  1  one-cycle barrel-shifter load select.
REQ-009 The block SHALL have port MS_1  output  1  shift-amount mux select: 1 = Exp differs from 127, 0 = shift by zero.
REQ-010 The block SHALL have port EN_REG_RESULT  output  1  one-cycle capture pulse for the FIXED result register.
REQ-011 The block SHALL have port OVF  output  1  exponent overflow flag, valid while ACK_FSM_CFF is 1.
REQ-012 The block SHALL have port ACK_FSM_CFF  output  1  conversion complete.

Function
REQ-013 The FSM SHALL have states IDLE, LOAD_FLOAT, COMPARE, SHIFT_LOAD, SHIFT_WAIT, CAPTURE and DONE; all outputs SHALL be registered Moore outputs.
REQ-014 IDLE SHALL go to LOAD_FLOAT when BEG_FSM_CFF=1 is sampled; otherwise it SHALL stay in IDLE.
REQ-015 LOAD_FLOAT SHALL assert EN_REG1 for exactly one cycle and then go to COMPARE.
REQ-016 COMPARE SHALL latch MS_1 = (Exp != 8'd127) on its exit edge and then go to SHIFT_LOAD; MS_1 SHALL hold that value until the FSM returns to IDLE.
REQ-017 SHIFT_LOAD SHALL assert LOAD for one cycle; Exp_out is valid from this cycle onward.
REQ-018 SHIFT_WAIT SHALL last exactly LAT_SHIFT cycles, counted by a 4-bit down-counter loaded on entry.
REQ-019 CAPTURE SHALL assert EN_REG_RESULT for one cycle and then go to DONE.
REQ-020 DONE SHALL hold ACK_FSM_CFF=1 while BEG_FSM_CFF=1 and SHALL go to IDLE on the first cycle BEG_FSM_CFF=0 is sampled; ACK_FSM_CFF SHALL drop in that same transition.
REQ-021 Latency SHALL be 5+LAT_SHIFT cycles from the edge sampling BEG_FSM_CFF=1 to ACK_FSM_CFF=1 (7 cycles at the default).
REQ-022 BEG_FSM_CFF changes outside IDLE and DONE SHALL be ignored; a started conversion always completes.
REQ-023 A new request SHALL be accepted only after the return to IDLE; back-to-back requests therefore have at least one IDLE cycle between them.
REQ-024 EN_REG1, LOAD and EN_REG_RESULT SHALL never be high in the same cycle.

Reset
REQ-025 When RST=0 at a clock edge, the FSM SHALL enter IDLE and all outputs SHALL be 0 after that edge, including mid-conversion.
REQ-026 The SHIFT_WAIT counter SHALL reset to 0.
REQ-027 After reset deassertion, a BEG_FSM_CFF already held at 1 SHALL start a conversion on the first sampling edge.

Configuration
REQ-028 With CFF_OVERFLOW_DET_EN defined, COMPARE with Exp > 8'd153 (shift beyond a 26-bit integer range) SHALL go directly to DONE with OVF=1, skipping LOAD and EN_REG_RESULT.
REQ-029 OVF SHALL clear on exit from DONE.
REQ-030 Without CFF_OVERFLOW_DET_EN, OVF SHALL be tied to 0 and COMPARE SHALL always go to SHIFT_LOAD.

Verification
REQ-031 Reset, then BEG=1 with Exp=8'd130 -> EN_REG1 pulse in cycle 1, LOAD in cycle 3, EN_REG_RESULT in cycle 6, ACK in cycle 7, MS_1=1.
REQ-032 Exp=8'd127 -> MS_1=0 from SHIFT_LOAD through DONE, same 7-cycle latency.
REQ-033 BEG held at 1 for 20 cycles -> ACK held from cycle 7 until BEG drops, then IDLE next edge, with no second conversion.
REQ-034 RST=0 asserted in SHIFT_WAIT -> all outputs 0 next edge; a new request then completes normally.
REQ-035 With CFF_OVERFLOW_DET_EN defined, Exp=8'd200 -> ACK and OVF=1 in cycle 3, with no LOAD and no EN_REG_RESULT pulses; without the macro -> normal 7-cycle flow and OVF=0.
REQ-036 LAT_SHIFT=4 with Exp=8'd120 -> ACK in cycle 9 and MS_1=1.
